// File: rtl/blake2_stream_pkg.sv
// Shared types and constants for the BLAKE2 stream sequencer.
package blake2_stream_pkg;

  // Sequencer states, in the order a job walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_DATA,
    ST_WAIT_HASH,
    ST_READ
  } state_e;

  // Command codes carried alongside every byte sent to the core.
  localparam logic [1:0] CMD_CFG  = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_LAST = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  // kk, nn, ll[7:0], ll[15:8]
  localparam int CFG_BYTES = 4;

  // Wide enough that nblk*BB for ll = 65535 does not wrap.
  localparam int IDX_W = 17;

  // Digest lengths of 0 or above the supported maximum fall back to the maximum.
  function automatic logic [7:0] clamp_nn(input logic [7:0] nn, input int nn_max);
    if (nn == 8'd0 || int'(nn) > nn_max) begin
      return 8'(nn_max);
    end
    return nn;
  endfunction

endpackage

// File: rtl/blake2_stream_cnt.sv
// Byte-index counter for the message phase: tracks position within the
// zero-padded block stream and flags message/last-block/end boundaries.
module blake2_stream_cnt
  import blake2_stream_pkg::*;
#(
  parameter int BB = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        adv,
  input  logic [15:0] ll,
  output logic        in_msg,
  output logic        last_blk,
  output logic        end_of_data
);

  localparam logic [IDX_W-1:0] BB_W      = IDX_W'(BB);
  localparam logic [IDX_W-1:0] BLK_MASK  = ~(BB_W - 17'd1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ll_w;
  logic [IDX_W-1:0] total;

  assign ll_w = {1'b0, ll};
  // An empty message still produces one (all-pad) block.
  assign total = (ll == 16'd0) ? BB_W : ((ll_w + BB_W - 17'd1) & BLK_MASK);

  assign in_msg      = (idx_q < ll_w);
  assign last_blk    = (idx_q >= (total - BB_W));
  assign end_of_data = (idx_q == (total - 17'd1));

  // Next byte index: cleared at job start, stepped on each accepted data byte.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d = idx_q + 17'd1;
    end
  end

  // Index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/blake2_stream_ctrl.sv
// Sequencer that pushes one BLAKE2 job (config, padded message) into the
// byte-wide core interface and collects the digest bytes that come back.
module blake2_stream_ctrl
  import blake2_stream_pkg::*;
#(
  parameter int BB      = 64,
  parameter int NN_MAX  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  kk_i,
  input  logic [7:0]  nn_i,
  input  logic [15:0] ll_i,
  input  logic        src_valid_i,
  input  logic [7:0]  src_data_i,
  output logic        src_ready_o,
  output logic        core_valid_o,
  output logic [1:0]  core_cmd_o,
  output logic [7:0]  core_data_o,
  input  logic        core_ready_i,
  input  logic        hash_valid_i,
  input  logic [7:0]  hash_i,
  output logic        dig_valid_o,
  output logic [7:0]  dig_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [7:0]      kk_q, kk_d;
  logic [7:0]      nn_q, nn_d;
  logic [15:0]     ll_q, ll_d;
  logic [1:0]      cfg_idx_q, cfg_idx_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      rd_cnt_q, rd_cnt_d;
  logic            core_valid_q, core_valid_d;
  logic [1:0]      core_cmd_q, core_cmd_d;
  logic [7:0]      core_data_q, core_data_d;
  logic            dig_valid_q, dig_valid_d;
  logic [7:0]      dig_data_q, dig_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic            cnt_clr, cnt_adv;
  logic            in_msg, last_blk, end_of_data;
  logic            in_data, core_fire, hash_take;
  logic [1:0]      cfg_nxt_idx;
  logic [7:0]      cfg_nxt_byte;

  blake2_stream_cnt #(
    .BB (BB)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .clr         (cnt_clr),
    .adv         (cnt_adv),
    .ll          (ll_q),
    .in_msg      (in_msg),
    .last_blk    (last_blk),
    .end_of_data (end_of_data)
  );

  // In DATA the message bytes flow straight from the source so they are not
  // delayed; pad bytes and command are derived from the registered index.
  assign in_data      = (state_q == ST_DATA);
  assign core_valid_o = in_data ? (in_msg ? src_valid_i : 1'b1) : core_valid_q;
  assign core_cmd_o   = in_data ? (last_blk ? CMD_LAST : CMD_DATA) : core_cmd_q;
  assign core_data_o  = in_data ? (in_msg ? src_data_i : 8'h00) : core_data_q;
  assign src_ready_o  = in_data & in_msg & core_ready_i;
  assign core_fire    = core_valid_o & core_ready_i;
  assign hash_take    = hash_valid_i & ((state_q == ST_WAIT_HASH) | (state_q == ST_READ));

  assign dig_valid_o  = dig_valid_q;
  assign dig_data_o   = dig_data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

  assign cfg_nxt_idx  = cfg_idx_q + 2'd1;

  // Select the configuration byte that follows the one currently on the bus.
  always_comb begin
    cfg_nxt_byte = kk_q;
    case (cfg_nxt_idx)
      2'd0:    cfg_nxt_byte = kk_q;
      2'd1:    cfg_nxt_byte = nn_q;
      2'd2:    cfg_nxt_byte = ll_q[7:0];
      default: cfg_nxt_byte = ll_q[15:8];
    endcase
  end

  // Job sequencing: next state, counters and registered outputs.
  always_comb begin
    state_d      = state_q;
    kk_d         = kk_q;
    nn_d         = nn_q;
    ll_d         = ll_q;
    cfg_idx_d    = cfg_idx_q;
    tmo_d        = tmo_q;
    rd_cnt_d     = rd_cnt_q;
    core_valid_d = core_valid_q;
    core_cmd_d   = core_cmd_q;
    core_data_d  = core_data_q;
    error_d      = error_q;
    done_d       = 1'b0;
    dig_valid_d  = hash_take;
    dig_data_d   = hash_take ? hash_i : dig_data_q;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          kk_d         = kk_i;
          nn_d         = clamp_nn(nn_i, NN_MAX);
          ll_d         = ll_i;
          error_d      = 1'b0;
          cnt_clr      = 1'b1;
          cfg_idx_d    = 2'd0;
          tmo_d        = '0;
          rd_cnt_d     = 8'd0;
          core_valid_d = 1'b1;
          core_cmd_d   = CMD_CFG;
          core_data_d  = kk_i;
          state_d      = ST_CFG;
        end
      end

      ST_CFG: begin
        if (core_fire) begin
          if (cfg_idx_q == 2'(CFG_BYTES - 1)) begin
            core_valid_d = 1'b0;
            core_data_d  = 8'h00;
            state_d      = ST_DATA;
          end else begin
            cfg_idx_d   = cfg_nxt_idx;
            core_data_d = cfg_nxt_byte;
          end
        end
      end

      ST_DATA: begin
        if (core_fire) begin
          cnt_adv = 1'b1;
          if (end_of_data) begin
            tmo_d   = '0;
            state_d = ST_WAIT_HASH;
          end
        end
      end

      ST_WAIT_HASH: begin
        if (hash_valid_i) begin
          rd_cnt_d = 8'd1;
          if (nn_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_READ;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_READ: begin
        if (hash_valid_i) begin
          rd_cnt_d = rd_cnt_q + 8'd1;
          if ((rd_cnt_q + 8'd1) == nn_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any job immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      kk_q         <= 8'h00;
      nn_q         <= 8'h00;
      ll_q         <= 16'h0000;
      cfg_idx_q    <= 2'd0;
      tmo_q        <= '0;
      rd_cnt_q     <= 8'd0;
      core_valid_q <= 1'b0;
      core_cmd_q   <= CMD_CFG;
      core_data_q  <= 8'h00;
      dig_valid_q  <= 1'b0;
      dig_data_q   <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      kk_q         <= kk_d;
      nn_q         <= nn_d;
      ll_q         <= ll_d;
      cfg_idx_q    <= cfg_idx_d;
      tmo_q        <= tmo_d;
      rd_cnt_q     <= rd_cnt_d;
      core_valid_q <= core_valid_d;
      core_cmd_q   <= core_cmd_d;
      core_data_q  <= core_data_d;
      dig_valid_q  <= dig_valid_d;
      dig_data_q   <= dig_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule
